// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold the value w (bit count of a conversion).
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble.sv
// Dabble add-3 cell: one BCD digit, corrected before each left shift.
module bin2bcd_seq_dabble
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    // Digits 5..9 get +3 so the following doubling carries into the next digit.
    always_comb begin
        dout = (din >= DIGIT_W'(5)) ? din + DIGIT_W'(3) : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One W-bit value per request; result after W shift cycles plus one DONE cycle.
// Optional macro BIN2BCD_BLANK_EN enables the registered leading-zero mask on
// blank; without it blank is tied to zero.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W      = 10,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [W-1:0]              bin,
    output logic                      ready,
    output logic                      done_tick,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]         blank
);

    localparam int CNT_W = cnt_width(W);
    localparam int BCD_W = DIGIT_W * DIGITS;

    state_t           state;
    logic [W-1:0]     shreg;
    logic [BCD_W-1:0] work_bcd;
    logic [CNT_W-1:0] cnt;

    logic [BCD_W-1:0] adj_bcd;
    logic [BCD_W-1:0] next_bcd;
    logic [W-1:0]     next_shreg;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dabble
        bin2bcd_seq_dabble u_dabble (
            .din  (work_bcd[k*DIGIT_W +: DIGIT_W]),
            .dout (adj_bcd[k*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits and shift register move left together by one bit.
    always_comb begin
        {next_bcd, next_shreg} = {adj_bcd, shreg} << 1;
    end

    // Control FSM with registered ready/done_tick and the result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done_tick <= 1'b0;
            bcd       <= '0;
            shreg     <= '0;
            work_bcd  <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_tick <= 1'b0;
                    if (start) begin
                        shreg    <= bin;
                        work_bcd <= '0;
                        cnt      <= CNT_W'(W);
                        ready    <= 1'b0;
                        state    <= OP;
                    end
                end
                OP: begin
                    work_bcd <= next_bcd;
                    shreg    <= next_shreg;
                    cnt      <= cnt - CNT_W'(1);
                    // Final shift: publish the shifted value directly so bcd
                    // is valid in the same cycle done_tick is high.
                    if (cnt == CNT_W'(1)) begin
                        bcd       <= next_bcd;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_tick <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    done_tick <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] next_blank;
    logic              zero_above;

    // Digit k is blanked when it and every more-significant digit are zero.
    always_comb begin
        next_blank = '0;
        zero_above = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            zero_above    = zero_above && (next_bcd[k*DIGIT_W +: DIGIT_W] == '0);
            next_blank[k] = zero_above;
        end
    end

    // Mask is captured on the same edge as bcd.
    always_ff @(posedge clk) begin
        if (reset) begin
            blank <= '0;
        end else if (state == OP && cnt == CNT_W'(1)) begin
            blank <= next_blank;
        end
    end
`else
    // Feature disabled: no mask logic.
    always_comb begin
        blank = '0;
    end
`endif

    // Dabble inputs must stay within 0..9 while shifting.
    always_ff @(posedge clk) begin
        if (!reset && state == OP) begin
            for (int unsigned k = 0; k < DIGITS; k++) begin
                assert (work_bcd[k*DIGIT_W +: DIGIT_W] <= DIGIT_W'(9));
            end
        end
    end

endmodule
